// File: rtl/cvxif_sched_pkg.sv
// Shared types for the CV-X-IF result scheduler: per-id scoreboard entry and helpers.
package cvxif_sched_pkg;

    typedef enum logic [1:0] {
        SB_FREE      = 2'd0,
        SB_ISSUED    = 2'd1,
        SB_COMMITTED = 2'd2,
        SB_KILLED    = 2'd3
    } sb_state_e;

    typedef struct packed {
        sb_state_e state;
        logic      we;
    } sb_entry_t;

    localparam sb_entry_t SbEntryReset = '{state: SB_FREE, we: 1'b0};

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cvxif_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle when gate_i is high; the pointer moves
// to the unit after the granted one.
module cvxif_rr_arbiter
    import cvxif_sched_pkg::*;
#(
    parameter int unsigned NrUnits = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NrUnits-1:0] req_i,
    input  logic               gate_i,
    output logic [NrUnits-1:0] gnt_o
);

    localparam int unsigned PtrW = ptr_width(NrUnits);

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;
    logic            found;
    int unsigned     idx;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < NrUnits; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NrUnits) begin
                idx = idx - NrUnits;
            end
            if (gate_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = (idx == NrUnits - 1) ? '0 : PtrW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cvxif_result_scheduler.sv
// Shares the CV-X-IF result channel between execution units, forwarding a result
// only after its id has been committed and silently dropping killed results.
module cvxif_result_scheduler
    import cvxif_sched_pkg::*;
#(
    parameter int unsigned NrUnits   = 2,
    parameter int unsigned IdWidth   = 3,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned RdWidth   = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_fire_i,
    input  logic                         issue_accept_i,
    input  logic                         issue_we_i,
    input  logic [IdWidth-1:0]           issue_id_i,
    input  logic                         commit_valid_i,
    input  logic [IdWidth-1:0]           commit_id_i,
    input  logic                         commit_kill_i,
    input  logic [NrUnits-1:0]           unit_valid_i,
    output logic [NrUnits-1:0]           unit_ready_o,
    input  logic [NrUnits*IdWidth-1:0]   unit_id_i,
    input  logic [NrUnits*DataWidth-1:0] unit_data_i,
    input  logic [NrUnits*RdWidth-1:0]   unit_rd_i,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [IdWidth-1:0]           result_id_o,
    output logic [DataWidth-1:0]         result_data_o,
    output logic [RdWidth-1:0]           result_rd_o,
    output logic                         result_we_o,
    output logic                         busy_o,
    output logic                         error_o
);

    localparam int unsigned NrIds = 2 ** IdWidth;

    sb_entry_t sb_q [NrIds];
    sb_entry_t sb_d [NrIds];

    logic                 out_valid_q;
    logic [IdWidth-1:0]   out_id_q;
    logic [DataWidth-1:0] out_data_q;
    logic [RdWidth-1:0]   out_rd_q;
    logic                 out_we_q;
    logic                 error_q;

    logic [NrUnits-1:0]   req;
    logic [NrUnits-1:0]   drop;
    logic [NrUnits-1:0]   gnt;
    logic                 err_unit;
    logic                 err_set;
    logic                 can_load;
    logic                 out_hs;
    logic [IdWidth-1:0]   gnt_id;
    logic [DataWidth-1:0] gnt_data;
    logic [RdWidth-1:0]   gnt_rd;
    logic                 any_busy;

    assign out_hs   = out_valid_q & result_ready_i;
    assign can_load = ~out_valid_q | result_ready_i;

    // Eligibility looks only at registered state, so a same-cycle commit stalls the unit.
    always_comb begin
        req      = '0;
        drop     = '0;
        err_unit = 1'b0;
        for (int unsigned u = 0; u < NrUnits; u++) begin
            if (unit_valid_i[u]) begin
                case (sb_q[unit_id_i[u*IdWidth +: IdWidth]].state)
                    SB_KILLED:    drop[u] = 1'b1;
                    SB_COMMITTED: req[u]  = 1'b1;
                    SB_FREE: begin
                        drop[u]  = 1'b1;
                        err_unit = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    cvxif_rr_arbiter #(
        .NrUnits (NrUnits)
    ) i_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req),
        .gate_i (can_load),
        .gnt_o  (gnt)
    );

    assign unit_ready_o = drop | gnt;

    always_comb begin
        gnt_id   = '0;
        gnt_data = '0;
        gnt_rd   = '0;
        for (int unsigned u = 0; u < NrUnits; u++) begin
            if (gnt[u]) begin
                gnt_id   = unit_id_i[u*IdWidth +: IdWidth];
                gnt_data = unit_data_i[u*DataWidth +: DataWidth];
                gnt_rd   = unit_rd_i[u*RdWidth +: RdWidth];
            end
        end
    end

    // Update order matters: handshake free and drops land before issue checks FREE.
    always_comb begin
        sb_d    = sb_q;
        err_set = err_unit;
        if (out_hs) begin
            sb_d[out_id_q] = SbEntryReset;
        end
        for (int unsigned u = 0; u < NrUnits; u++) begin
            if (drop[u]) begin
                sb_d[unit_id_i[u*IdWidth +: IdWidth]] = SbEntryReset;
            end
        end
        if (commit_valid_i) begin
            if (sb_q[commit_id_i].state == SB_ISSUED) begin
                sb_d[commit_id_i].state = commit_kill_i ? SB_KILLED : SB_COMMITTED;
            end else begin
                err_set = 1'b1;
            end
        end
        if (issue_fire_i && issue_accept_i) begin
            if (sb_d[issue_id_i].state == SB_FREE) begin
                sb_d[issue_id_i] = '{state: SB_ISSUED, we: issue_we_i};
            end else begin
                err_set = 1'b1;
            end
        end
    end

    always_comb begin
        any_busy = out_valid_q;
        for (int unsigned i = 0; i < NrIds; i++) begin
            if (sb_q[i].state != SB_FREE) begin
                any_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrIds; i++) begin
                sb_q[i] <= SbEntryReset;
            end
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            sb_q    <= sb_d;
            error_q <= error_q | err_set;
            if (can_load) begin
                out_valid_q <= |gnt;
                if (|gnt) begin
                    out_id_q   <= gnt_id;
                    out_data_q <= gnt_data;
                    out_rd_q   <= gnt_rd;
                    out_we_q   <= sb_q[gnt_id].we;
                end
            end
        end
    end

    assign result_valid_o = out_valid_q;
    assign result_id_o    = out_id_q;
    assign result_data_o  = out_data_q;
    assign result_rd_o    = out_rd_q;
    assign result_we_o    = out_we_q;
    assign busy_o         = any_busy;
    assign error_o        = error_q;

endmodule
